mac_accumulator: RTL and testbench
==================================

MAC_ACCUMULATOR -- requirements
Module: mac_accumulator

Interface
REQ-001 The block SHALL have exactly one clock, clk; reset is synchronous and active-high, named reset.
REQ-002 clk  input  1  rising-edge clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous active-high reset; sampled only on posedge clk.
REQ-004 p_in  input  8  unsigned product from the upstream 4x4 array multiplier (range 0..225).
REQ-005 p_valid  input  1  p_in/p_last valid this cycle.
REQ-006 p_last  input  1  marks the final product of a dot-product frame.
REQ-007 p_ready  output  1  block can accept a product this cycle.
REQ-008 sum_out  output  12  unsigned accumulated frame sum.
REQ-009 sum_count  output  5  number of products in the frame (1..16).
REQ-010 sum_trunc  output  1  frame closed by the length limit, not by p_last.
REQ-011 sum_valid  output  1  sum_out/sum_count/sum_trunc valid.
REQ-012 sum_ready  input  1  downstream accepts the result this cycle.

Function
REQ-013 A product beat SHALL be accepted in a cycle where p_valid and p_ready are both 1; no other cycle changes the accumulator.
REQ-014 The FSM SHALL have two states: ACC (p_ready=1, sum_valid=0) and HOLD (p_ready=0, sum_valid=1).
REQ-015 In ACC, each accepted beat SHALL add zero-extended p_in to the 12-bit accumulator and increment the 5-bit beat counter.
REQ-016 ACC->HOLD SHALL occur on an accepted beat with p_last=1, or on the 16th accepted beat of a frame; the accepted beat is included in the sum.
REQ-017 On the 16th beat with p_last=0, sum_trunc SHALL be 1; with p_last=1 on any beat, including the 16th, sum_trunc SHALL be 0.
REQ-018 Latency: sum_valid SHALL rise on the clock edge that accepts the closing beat, so it is visible the following cycle with the final sum.
REQ-019 sum_out, sum_count and sum_trunc SHALL stay stable while sum_valid=1 and sum_ready=0.
REQ-020 HOLD->ACC SHALL occur on the edge where sum_ready=1; the accumulator and counter clear to 0 on that same edge.
REQ-021 p_ready SHALL be 0 for the whole HOLD state, including the handoff cycle; a product offered then is not accepted and waits for the next cycle.
REQ-022 Arithmetic SHALL never wrap: the maximum is 16 x 225 = 3600 < 4096, so no overflow logic is needed.
REQ-023 p_in SHALL be ignored when p_valid=0; p_last SHALL be ignored when p_valid=0 or p_ready=0.
REQ-024 In ACC, sum_out SHALL expose the running partial sum and sum_count the beats accepted so far, both qualified only by sum_valid.

Reset
REQ-025 On reset=1 the block SHALL enter ACC with accumulator=0, counter=0, sum_out=0, sum_count=0, sum_trunc=0 and sum_valid=0; p_ready=1 from the next cycle.
REQ-026 Reset asserted mid-frame or in HOLD SHALL discard the partial or pending result without emitting it.
REQ-027 Reset SHALL take priority over simultaneous p_valid and sum_ready.

Verification
REQ-028 Frame {15,225,0,4} with p_last on the 4th beat, sum_ready held 1 -> one cycle later sum_valid=1, sum_out=244, sum_count=4, sum_trunc=0.
REQ-029 16 beats of 225 with p_last=0 throughout -> sum_out=3600, sum_count=16, sum_trunc=1, and p_ready=0 until sum_ready=1.
REQ-030 Single beat p_in=9 with p_last=1, sum_ready=0 for 5 cycles -> sum_out=9 and sum_count=1 stable for all 5 cycles, p_ready=0; after sum_ready=1, sum_valid=0 and p_ready=1 next cycle.
REQ-031 Back-to-back frames {3,p_last} then {7,p_last} with p_valid held 1 -> results 3 and 7 in order, the second not contaminated by the first, and the beat 7 accepted only after the handoff.
REQ-032 Reset asserted after beats {100,50} of an unterminated frame, then frame {1,p_last} -> no result for the aborted frame; next result sum_out=1, sum_count=1.
REQ-033 p_valid toggling with bubbles on frame {2,0,5,p_last} -> sum_out=7, sum_count=3, sum_trunc=0.

Source files
------------

// File: rtl/mac_accumulator.sv
// Dot-product frame accumulator: sums unsigned 4x4 multiplier products into a 12-bit total.
// A frame is closed by p_last or by the 16-beat length limit, and the result is held until it is taken.
module mac_accumulator (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  p_in,
  input  logic        p_valid,
  input  logic        p_last,
  output logic        p_ready,
  output logic [11:0] sum_out,
  output logic [4:0]  sum_count,
  output logic        sum_trunc,
  output logic        sum_valid,
  input  logic        sum_ready
);

  // state | meaning
  // ACC   | accepting products, sum_out/sum_count show the running partial result
  // HOLD  | frame closed, result presented until sum_ready
  typedef enum logic {ACC, HOLD} state_t;

  state_t      state;
  logic [11:0] acc;
  logic [4:0]  cnt;
  logic        trunc;
  logic        accept;
  logic        close;

  assign accept = (state == ACC) && p_valid;
  // The 16th beat closes the frame even without p_last; 16 x 225 fits in 12 bits, so no wrap check.
  assign close  = p_last || (cnt == 5'd15);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ACC;
      acc       <= '0;
      cnt       <= '0;
      trunc     <= 1'b0;
      sum_valid <= 1'b0;
      p_ready   <= 1'b1;
    end else begin
      case (state)
        ACC: begin
          if (accept) begin
            acc <= acc + {4'b0000, p_in};
            cnt <= cnt + 5'd1;
            if (close) begin
              state     <= HOLD;
              trunc     <= ~p_last;
              sum_valid <= 1'b1;
              p_ready   <= 1'b0;
            end
          end
        end
        HOLD: begin
          if (sum_ready) begin
            state     <= ACC;
            acc       <= '0;
            cnt       <= '0;
            trunc     <= 1'b0;
            sum_valid <= 1'b0;
            p_ready   <= 1'b1;
          end
        end
        default: begin
          state     <= ACC;
          acc       <= '0;
          cnt       <= '0;
          trunc     <= 1'b0;
          sum_valid <= 1'b0;
          p_ready   <= 1'b1;
        end
      endcase
    end
  end

  assign sum_out   = acc;
  assign sum_count = cnt;
  assign sum_trunc = trunc;

endmodule

// File: tb/tb_mac_accumulator.sv
// Bench for mac_accumulator: directed frames plus random traffic against a queue-based frame model.
module tb_mac_accumulator;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  p_in;
  logic        p_valid;
  logic        p_last;
  logic        p_ready;
  logic [11:0] sum_out;
  logic [4:0]  sum_count;
  logic        sum_trunc;
  logic        sum_valid;
  logic        sum_ready;

  int checks = 0;
  int failures = 0;

  // Model: products of the open (or held) frame, whether a result is pending, and how it closed.
  int frame[$];
  bit m_hold = 1'b0;
  bit m_trunc = 1'b0;
  bit m_known = 1'b0;
  int dut_results[$];

  mac_accumulator dut (
    .clk(clk), .reset(reset), .p_in(p_in), .p_valid(p_valid), .p_last(p_last),
    .p_ready(p_ready), .sum_out(sum_out), .sum_count(sum_count), .sum_trunc(sum_trunc),
    .sum_valid(sum_valid), .sum_ready(sum_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int frame_sum();
    int s = 0;
    foreach (frame[i]) s += frame[i];
    return s;
  endfunction

  task automatic check_model();
    chk("p_ready",   32'(p_ready),   32'(!m_hold));
    chk("sum_valid", 32'(sum_valid), 32'(m_hold));
    chk("sum_out",   32'(sum_out),   32'(frame_sum()));
    chk("sum_count", 32'(sum_count), 32'(frame.size()));
    chk("sum_trunc", 32'(sum_trunc), 32'(m_trunc));
  endtask

  // One clock: check outputs mid-cycle, drive inputs, then advance the model across the edge.
  task automatic step(input logic rst, input logic pv, input logic [7:0] pin,
                      input logic pl, input logic sr);
    @(negedge clk);
    if (m_known) check_model();
    reset = rst; p_valid = pv; p_in = pin; p_last = pl; sum_ready = sr;
    if (!rst && sr && sum_valid === 1'b1) dut_results.push_back(int'(sum_out));
    @(posedge clk);
    if (rst) begin
      frame.delete(); m_hold = 0; m_trunc = 0; m_known = 1;
    end else if (m_hold) begin
      if (sr) begin frame.delete(); m_hold = 0; m_trunc = 0; end
    end else if (pv) begin
      frame.push_back(int'(pin));
      if (pl || frame.size() == 16) begin
        m_hold = 1;
        m_trunc = !pl;
      end
    end
  endtask

  initial begin
    reset = 1'b1; p_valid = 1'b0; p_in = '0; p_last = 1'b0; sum_ready = 1'b0;
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    #1;
    chk("reset_p_ready", 32'(p_ready), 32'd1);
    chk("reset_sum_out", 32'(sum_out), 32'd0);

    // Four-beat frame closed by p_last.
    step(0, 1, 15, 0, 1);
    step(0, 1, 225, 0, 1);
    step(0, 1, 0, 0, 1);
    step(0, 1, 4, 1, 1);
    #1;
    chk("f1_valid", 32'(sum_valid), 32'd1);
    chk("f1_sum",   32'(sum_out),   32'd244);
    chk("f1_count", 32'(sum_count), 32'd4);
    chk("f1_trunc", 32'(sum_trunc), 32'd0);
    step(0, 0, 0, 0, 1);

    // Sixteen beats of the maximum product, no p_last.
    for (int i = 0; i < 16; i++) step(0, 1, 225, 0, 0);
    #1;
    chk("f2_sum",   32'(sum_out),   32'd3600);
    chk("f2_count", 32'(sum_count), 32'd16);
    chk("f2_trunc", 32'(sum_trunc), 32'd1);
    chk("f2_ready", 32'(p_ready),   32'd0);
    for (int i = 0; i < 3; i++) step(0, 1, 225, 0, 0);
    step(0, 0, 0, 0, 1);

    // Single beat held under backpressure.
    step(0, 1, 9, 1, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 8'($urandom_range(0, 225)), 1, 0);
      #1;
      chk("f3_hold_sum",   32'(sum_out),   32'd9);
      chk("f3_hold_count", 32'(sum_count), 32'd1);
      chk("f3_hold_ready", 32'(p_ready),   32'd0);
    end
    step(0, 0, 0, 0, 1);
    #1;
    chk("f3_after_valid", 32'(sum_valid), 32'd0);
    chk("f3_after_ready", 32'(p_ready),   32'd1);

    // Back-to-back frames with p_valid held high.
    dut_results.delete();
    step(0, 1, 3, 1, 1);
    step(0, 1, 7, 1, 1);
    step(0, 1, 7, 1, 1);
    step(0, 0, 0, 0, 1);
    chk("b2b_n", 32'(dut_results.size()), 32'd2);
    if (dut_results.size() == 2) begin
      chk("b2b_first",  32'(dut_results[0]), 32'd3);
      chk("b2b_second", 32'(dut_results[1]), 32'd7);
    end

    // Reset aborts a partial frame; reset wins over valid and ready.
    dut_results.delete();
    step(0, 1, 100, 0, 1);
    step(0, 1, 50, 0, 1);
    step(1, 1, 1, 1, 1);
    step(0, 1, 1, 1, 0);
    #1;
    chk("abort_sum",   32'(sum_out),   32'd1);
    chk("abort_count", 32'(sum_count), 32'd1);
    step(0, 0, 0, 0, 1);
    chk("abort_n", 32'(dut_results.size()), 32'd1);
    if (dut_results.size() == 1) chk("abort_res", 32'(dut_results[0]), 32'd1);

    // Bubbles between beats; p_last on an invalid cycle is ignored.
    step(0, 1, 2, 0, 0);
    step(0, 0, 99, 1, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 1, 5, 1, 0);
    #1;
    chk("bub_sum",   32'(sum_out),   32'd7);
    chk("bub_count", 32'(sum_count), 32'd3);
    chk("bub_trunc", 32'(sum_trunc), 32'd0);
    step(0, 0, 0, 0, 1);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 299) == 0),
           ($urandom_range(0, 3) != 0),
           8'($urandom_range(0, 225)),
           ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 1) == 1));
    end
    step(0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
